muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width (even, >=8).
REQ-002 SHALL have parameter OPCODE_LENGTH, default 3, Operation width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port Kill  input  1  abort of the in-flight operation (pipeline flush).
REQ-007 SHALL have port Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port SrcA  input  DATA_WIDTH  multiplicand or dividend.
REQ-009 SHALL have port SrcB  input  DATA_WIDTH  multiplier or divisor.
REQ-010 SHALL have port Busy  output  1  high while in CALC.
REQ-011 SHALL have port Done  output  1  one-cycle pulse; Result valid.
REQ-012 SHALL have port Result  output  DATA_WIDTH  registered result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept a request on a rising edge in IDLE with Start=1 and Kill=0, latching Operation, SrcA and SrcB; later input changes have no effect.
REQ-015 SHALL move from IDLE to CALC on accept, except for the special cases in REQ-020 and REQ-021, which go to DONE.
REQ-016 SHALL perform one iteration per clock in CALC: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-017 SHALL run exactly DATA_WIDTH iterations, then enter DONE, so Done is high in the cycle DATA_WIDTH clocks after the accept edge.
REQ-018 SHALL compute multiply as a 2*DATA_WIDTH-bit product.
  - MUL returns the low half.
  - MULH treats both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; MULHU treats both as unsigned.
  - MULH, MULHSU and MULHU return the high half.
  - Sign is fixed by two's-complement negation of the full product when exactly one signed operand is negative.
REQ-019 SHALL truncate signed division toward zero.
  - Remainder takes the sign of the dividend.
  - DIVU and REMU are unsigned.
REQ-020 SHALL handle divide by zero (SrcB=0) without iterating.
  - DIV/DIVU returns all ones; REM/REMU returns SrcA.
  - Done is high one cycle after accept.
REQ-021 SHALL handle signed overflow (DIV/REM with SrcA=most-negative, SrcB=all ones) without iterating.
  - DIV returns SrcA; REM returns 0.
  - Done is high one cycle after accept.
REQ-022 SHALL update Result only on the edge entering DONE.
  - Result holds that value until the next completed operation.
REQ-023 SHALL hold Done high for exactly one cycle (DONE state), then return to IDLE; Busy=0 in DONE.
REQ-024 SHALL ignore Start while in CALC or DONE; no queuing.
REQ-025 SHALL respond to Kill=1 in CALC or DONE by returning to IDLE on that edge.
  - No Done pulse is produced.
  - Result is unchanged.
REQ-026 SHALL give Kill priority over Start in the same IDLE cycle; the request is not accepted.
REQ-027 SHALL allow a new Start to be accepted in the cycle after DONE (back-to-back issue).

Reset
REQ-028 SHALL, while reset_n=0 (asynchronous), force state=IDLE, Busy=0, Done=0, Result=0, and clear the iteration counter and internal registers.
REQ-029 SHALL abandon an operation interrupted by reset; the first Start after reset_n rises is accepted normally.

Verification (DATA_WIDTH=32)
REQ-030 MUL SrcA=7, SrcB=0xFFFFFFFD -> Result 0xFFFFFFEB; Done exactly 32 cycles after accept; Busy high for 31 cycles before it.
REQ-031 Multiply high halves:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 Divide and remainder:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 Special cases, each with Done one cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-034 Start pulsed during CALC -> ignored, first result intact; Kill on 10th CALC cycle -> Busy=0 next cycle, no Done, Result keeps prior value.
REQ-035 reset_n low mid-CALC -> Busy, Done, Result immediately 0; next DIVU 9/3 after release -> 3.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative integer multiply/divide unit (RV32M-style operation set).
//   Multiply uses shift-add and divide uses restoring shift-subtract, both on
//   operand magnitudes, one iteration per clock, DATA_WIDTH iterations total.
//   Sign correction is applied once, when the final result is written.
//   Divide-by-zero and signed overflow complete without iterating.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   Start      : request, accepted only in IDLE and only when Kill is low
//   Kill       : abort the in-flight operation (no Done, Result unchanged)
//   Operation  : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   SrcA       : multiplicand / dividend
//   SrcB       : multiplier / divisor
//   Busy       : high while iterating (CALC)
//   Done       : one-cycle pulse, Result valid
//   Result     : registered result, held until the next completed operation
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     Start,
  input  logic                     Kill,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(3);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(7);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [OPCODE_LENGTH-1:0]   op_q, op_d;
  logic                       neg_q, neg_d;
  logic [W-1:0]               hi_q, hi_d;
  logic [W-1:0]               lo_q, lo_d;
  logic [W-1:0]               b_q, b_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [W-1:0]               result_q, result_d;

  // One iteration over the {hi, lo} pair.
  //   multiply: hi accumulates, lo holds the remaining multiplier bits and
  //             collects product low bits as the pair shifts right.
  //   divide:   hi is the partial remainder, lo shifts the dividend out at the
  //             top and the quotient bits in at the bottom.
  function automatic logic [2*W-1:0] step(input logic         div,
                                          input logic [W-1:0] hi,
                                          input logic [W-1:0] lo,
                                          input logic [W-1:0] b);
    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic [2*W-1:0] r;
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[W-1]};
    // Partial remainder is always below the divisor, so shifted < 2*b and the
    // top bit of diff is a reliable borrow flag.
    diff    = shifted - {1'b0, b};
    if (div) begin
      if (!diff[W]) r = {diff[W-1:0], lo[W-2:0], 1'b1};
      else          r = {shifted[W-1:0], lo[W-2:0], 1'b0};
    end else begin
      r = {sum[W:1], sum[0], lo[W-1:1]};
    end
    return r;
  endfunction

  // Request decode (only meaningful in IDLE)
  logic           in_div;
  logic           in_a_sgn, in_b_sgn;
  logic           in_a_neg, in_b_neg;
  logic [W-1:0]   in_a_mag, in_b_mag;
  logic           in_neg;
  logic           in_div_zero, in_ovf;
  logic [W-1:0]   in_special_res;
  logic [2*W-1:0] init_step;

  // Iteration datapath (CALC)
  logic           cur_div;
  logic [2*W-1:0] calc_step;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  logic [W-1:0]   final_res;

  always_comb begin
    in_div   = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
               (Operation == OP_REM) || (Operation == OP_REMU);
    in_a_sgn = (Operation == OP_MULH) || (Operation == OP_MULHSU) ||
               (Operation == OP_DIV)  || (Operation == OP_REM);
    in_b_sgn = (Operation == OP_MULH) || (Operation == OP_DIV) ||
               (Operation == OP_REM);
    in_a_neg = in_a_sgn & SrcA[W-1];
    in_b_neg = in_b_sgn & SrcB[W-1];
    in_a_mag = in_a_neg ? (~SrcA + 1'b1) : SrcA;
    in_b_mag = in_b_neg ? (~SrcB + 1'b1) : SrcB;
    // Remainder follows the dividend's sign; everything else the XOR of signs.
    in_neg   = (Operation == OP_REM) ? in_a_neg : (in_a_neg ^ in_b_neg);

    in_div_zero = in_div && (SrcB == '0);
    in_ovf      = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                  (SrcA == MOST_NEG) && (SrcB == '1);
    if (in_div_zero) begin
      in_special_res = ((Operation == OP_DIV) || (Operation == OP_DIVU)) ? '1 : SrcA;
    end else begin
      in_special_res = (Operation == OP_DIV) ? SrcA : '0;
    end

    // The accept edge performs the first iteration; CALC supplies the rest.
    init_step = step(in_div, '0, in_a_mag, in_b_mag);
  end

  always_comb begin
    cur_div   = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                (op_q == OP_REM) || (op_q == OP_REMU);
    calc_step = step(cur_div, hi_q, lo_q, b_q);

    // Final sign correction on the full-width values of the last iteration.
    prod_fix  = neg_q ? (~calc_step + 1'b1) : calc_step;
    quo_fix   = neg_q ? (~calc_step[W-1:0] + 1'b1) : calc_step[W-1:0];
    rem_fix   = neg_q ? (~calc_step[2*W-1:W] + 1'b1) : calc_step[2*W-1:W];

    if (op_q == OP_MUL) begin
      final_res = prod_fix[W-1:0];
    end else if ((op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU)) begin
      final_res = prod_fix[2*W-1:W];
    end else if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
      final_res = quo_fix;
    end else begin
      final_res = rem_fix;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (Start && !Kill) begin
          op_d  = Operation;
          neg_d = in_neg;
          b_d   = in_b_mag;
          cnt_d = CW'(1);
          if (in_div_zero || in_ovf) begin
            state_d  = DONE;
            result_d = in_special_res;
          end else begin
            state_d        = CALC;
            {hi_d, lo_d}   = init_step;
          end
        end
      end
      CALC: begin
        if (Kill) begin
          state_d = IDLE;
        end else begin
          {hi_d, lo_d} = calc_step;
          if (cnt_q == CW'(W - 1)) begin
            state_d  = DONE;
            result_d = final_res;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    Busy   = (state_q == CALC);
    Done   = (state_q == DONE);
    Result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          Start     = 1'b0;
  logic          Kill      = 1'b0;
  logic [2:0]    Operation = 3'd0;
  logic [W-1:0]  SrcA      = '0;
  logic [W-1:0]  SrcB      = '0;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Result;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Start     (Start),
    .Kill      (Kill),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic, straight from the operation definitions.
  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = '0;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'b0, b}); r = sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (op >= 3'd4 && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // Protocol model: phase 0 idle, 1 iterating, 2 result cycle.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase  = 0;
      m_left   = 0;
      m_result = '0;
    end else begin
      case (m_phase)
        0: if (Start && !Kill) begin
          if (is_special(Operation, SrcA, SrcB)) begin
            m_result = ref_fn(Operation, SrcA, SrcB);
            m_phase  = 2;
          end else begin
            m_pend  = ref_fn(Operation, SrcA, SrcB);
            m_left  = W - 1;
            m_phase = 1;
          end
        end
        1: if (Kill) m_phase = 0;
           else begin
             m_left = m_left - 1;
             if (m_left == 0) begin
               m_result = m_pend;
               m_phase  = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare outputs with the model.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("cyc_busy",   {31'b0, Busy}, {31'b0, m_phase == 1});
      check("cyc_done",   {31'b0, Done}, {31'b0, m_phase == 2});
      check("cyc_result", Result, m_result);
    end
  endtask

  // Issue one operation and wait for Done. poke>0 pulses a competing Start
  // in that CALC cycle, which must be ignored.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int poke);
    int cycles;
    int busy;
    check({"model_", name}, ref_fn(op, a, b), exp);
    Operation = op; SrcA = a; SrcB = b; Start = 1'b1;
    cycles = 0; busy = 0;
    do begin
      tick();
      cycles++;
      if (Busy) busy++;
      if (cycles == poke) begin
        Start = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
      end else begin
        Start = 1'b0; Operation = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      end
    end while (!Done && cycles < 100);
    check({"lat_", name},  cycles, lat);
    check({"busy_", name}, busy, lat - 1);
    check({"res_", name},  Result, exp);
    Start = 1'b0;
    tick();
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0;
    chk_en  = 1'b1;
    tick();
    check("rst_busy",   {31'b0, Busy}, 32'd0);
    check("rst_done",   {31'b0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, -1);
    run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32, -1);
    run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, -1);
    run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32, -1);
    run_op("mulhsu2", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32, -1);
    run_op("mul2",    3'd0, 32'h12345678, 32'h10,       32'h23456780, 32, -1);
    run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, -1);
    run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, -1);
    run_op("div2",    3'd4, 32'h80000000, 32'd3,        32'hD5555556, 32, -1);
    run_op("rem2",    3'd6, 32'h80000000, 32'd3,        32'hFFFFFFFE, 32, -1);
    run_op("divu",    3'd5, 32'd100,      32'd7,        32'd14,       32, -1);
    run_op("remu",    3'd7, 32'd100,      32'd7,        32'd2,        32, -1);
    run_op("divu1",   3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32, -1);
    run_op("div0",    3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  -1);
    run_op("remu0",   3'd7, 32'd5,        32'd0,        32'd5,        1,  -1);
    run_op("divovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  -1);
    run_op("removf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  -1);
    run_op("poke",    3'd5, 32'd100,      32'd7,        32'd14,       32, 5);

    // Kill has priority over Start in IDLE
    Start = 1'b1; Kill = 1'b1; Operation = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
    tick();
    check("killidle_busy", {31'b0, Busy}, 32'd0);
    Start = 1'b0; Kill = 1'b0;
    tick();

    // Kill in the 10th CALC cycle
    Operation = 3'd3; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("kill_busy_before", {31'b0, Busy}, 32'd1);
    Kill = 1'b1;
    tick();
    Kill = 1'b0;
    check("kill_busy",   {31'b0, Busy}, 32'd0);
    check("kill_done",   {31'b0, Done}, 32'd0);
    check("kill_result", Result, 32'd14);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) done_seen++;
    end
    check("kill_nodone", done_seen, 0);

    // Reset in the middle of CALC
    Operation = 3'd0; SrcA = 32'd11; SrcB = 32'd13; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy",   {31'b0, Busy}, 32'd0);
    check("arst_done",   {31'b0, Done}, 32'd0);
    check("arst_result", Result, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_op("divu_rst", 3'd5, 32'd9, 32'd3, 32'd3, 32, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
